// File: rtl/lcu_pix_sp_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module  : lcu_pix_sp_ctrl_pkg
// Brief   : Shared constants and state encoding for the LCU pixel RAM controller.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package lcu_pix_sp_ctrl_pkg;

    localparam int LCU_WORD_NUM = 1536;
    localparam int LCU_ADR_WD   = 11;
    localparam int LCU_DAT_WD   = 32;
    localparam int LCU_PIX_WD   = 8;

    typedef logic [1:0] lcu_state_t;

    localparam lcu_state_t ST_IDLE  = 2'd0;
    localparam lcu_state_t ST_LOAD  = 2'd1;
    localparam lcu_state_t ST_READY = 2'd2;

endpackage

`default_nettype wire

// File: rtl/lcu_pix_pack.sv
//------------------------------------------------------------------------------
// Module  : lcu_pix_pack
// Brief   : Little-endian 8-to-32 bit pixel packer with a one-word write buffer.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lcu_pix_pack
    import lcu_pix_sp_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  i_clr,
    input  logic                  i_en,
    input  logic                  i_dat_val,
    input  logic [LCU_PIX_WD-1:0] i_dat,
    input  logic                  i_wr_go,
    output logic                  o_dat_rdy,
    output logic                  o_wr_pend,
    output logic [LCU_DAT_WD-1:0] o_wr_dat
);

    logic [1:0]              r_byte_cnt;
    logic [3*LCU_PIX_WD-1:0] r_pack;
    logic [LCU_DAT_WD-1:0]   r_wr_buf;
    logic                    r_wr_pend;
    logic                    w_dat_rdy;
    logic                    w_acc;
    logic                    w_word_done;

    // A fourth byte can only be taken once the previous word has left the buffer.
    assign w_dat_rdy   = i_en && !(r_wr_pend && (r_byte_cnt == 2'd3));
    assign w_acc       = i_dat_val && w_dat_rdy;
    assign w_word_done = w_acc && (r_byte_cnt == 2'd3);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_byte_cnt <= 2'd0;
            r_pack     <= '0;
            r_wr_buf   <= '0;
            r_wr_pend  <= 1'b0;
        end else if (i_clr) begin
            r_byte_cnt <= 2'd0;
            r_pack     <= '0;
            r_wr_pend  <= 1'b0;
        end else begin
            if (w_acc) begin
                case (r_byte_cnt)
                    2'd0:    r_pack[7:0]   <= i_dat;
                    2'd1:    r_pack[15:8]  <= i_dat;
                    2'd2:    r_pack[23:16] <= i_dat;
                    default: r_wr_buf      <= {i_dat, r_pack};
                endcase
                r_byte_cnt <= r_byte_cnt + 2'd1;
            end
            if (w_word_done) begin
                r_wr_pend <= 1'b1;
            end else if (i_wr_go) begin
                r_wr_pend <= 1'b0;
            end
        end
    end

    assign o_dat_rdy = w_dat_rdy;
    assign o_wr_pend = r_wr_pend;
    assign o_wr_dat  = r_wr_buf;

endmodule

`default_nettype wire

// File: rtl/lcu_pix_sp_ctrl.sv
//------------------------------------------------------------------------------
// Module  : lcu_pix_sp_ctrl
// Brief   : Loads one 64x64 YUV420 LCU into a 1536x32 single-port RAM and then
//           serves word reads; owns all port arbitration.
//           Define LCU_PIX_RD_DURING_LOAD_EN to serve reads (with priority)
//           while a load is in progress.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lcu_pix_sp_ctrl
    import lcu_pix_sp_ctrl_pkg::*;
#(
    parameter int WORD_NUM = LCU_WORD_NUM,
    parameter int ADR_WD   = LCU_ADR_WD,
    parameter int DAT_WD   = LCU_DAT_WD
)(
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    input  logic                  dat_val_i,
    output logic                  dat_rdy_o,
    input  logic [LCU_PIX_WD-1:0] dat_i,
    input  logic                  rd_req_i,
    input  logic [ADR_WD-1:0]     rd_adr_i,
    output logic                  rd_val_o,
    output logic [DAT_WD-1:0]     rd_dat_o,
    output logic [ADR_WD-1:0]     ram_adr_o,
    output logic                  ram_wr_ena_o,
    output logic [DAT_WD-1:0]     ram_wr_dat_o,
    output logic                  ram_rd_ena_o,
    input  logic [DAT_WD-1:0]     ram_rd_dat_i
);

    localparam logic [ADR_WD-1:0] c_LAST_ADR = ADR_WD'(WORD_NUM - 1);

    lcu_state_t          r_state;
    lcu_state_t          w_state_nxt;
    logic [ADR_WD-1:0]   r_wr_adr;
    logic                r_done;
    logic                r_rd_val;

    logic                w_in_load;
    logic                w_clr;
    logic                w_rd_win;
    logic                w_rd_ok;
    logic                w_wr_block;
    logic                w_wr_pend;
    logic                w_wr_go;
    logic                w_last;
    logic                w_dat_rdy;
    logic [DAT_WD-1:0]   w_wr_dat;

    assign w_in_load = (r_state == ST_LOAD);
    assign w_clr     = start_i && !w_in_load;
    assign w_last    = (r_wr_adr == c_LAST_ADR);

`ifdef LCU_PIX_RD_DURING_LOAD_EN
    assign w_rd_win   = (r_state == ST_READY) || w_in_load;
    assign w_wr_block = rd_req_i;
`else
    assign w_rd_win   = (r_state == ST_READY);
    assign w_wr_block = 1'b0;
`endif

    assign w_rd_ok = rd_req_i && w_rd_win && (rd_adr_i <= c_LAST_ADR);
    assign w_wr_go = w_in_load && w_wr_pend && !w_wr_block;

    lcu_pix_pack u_pack (
        .clk       (clk),
        .rstn      (rstn),
        .i_clr     (w_clr),
        .i_en      (w_in_load),
        .i_dat_val (dat_val_i),
        .i_dat     (dat_i),
        .i_wr_go   (w_wr_go),
        .o_dat_rdy (w_dat_rdy),
        .o_wr_pend (w_wr_pend),
        .o_wr_dat  (w_wr_dat)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_wr_go && w_last) begin
                    w_state_nxt = ST_READY;
                end
            end
            ST_READY: begin
                if (start_i) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Reads win the address bus; a write only drives it when no read is issued.
    always_comb begin
        busy_o       = w_in_load;
        dat_rdy_o    = w_dat_rdy;
        ram_rd_ena_o = w_rd_ok;
        ram_wr_ena_o = w_wr_go;
        ram_adr_o    = '0;
        if (w_rd_ok) begin
            ram_adr_o = rd_adr_i;
        end else if (w_wr_go) begin
            ram_adr_o = r_wr_adr;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_adr <= '0;
            r_done   <= 1'b0;
            r_rd_val <= 1'b0;
        end else begin
            r_done   <= w_wr_go && w_last;
            r_rd_val <= w_rd_ok;
            if (w_clr) begin
                r_wr_adr <= '0;
            end else if (w_wr_go && !w_last) begin
                r_wr_adr <= r_wr_adr + 1'b1;
            end
        end
    end

    assign done_o       = r_done;
    assign rd_val_o     = r_rd_val;
    assign rd_dat_o     = ram_rd_dat_i;
    assign ram_wr_dat_o = w_wr_dat;

endmodule

`default_nettype wire
